// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Port 0 is the CPU data port and port 1 is the loader/DMA port.
// Each access takes three cycles: IDLE (grant), ACCESS (memory strobe) and RESP (ack).
// An address outside the memory window is acknowledged with err set and
// never reaches the memory strobes.
module mem_arbiter #(
  parameter logic [15:0] MEM_ADDR = 16'h1000,
  parameter logic        RR_INIT  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [1:0]  p0_size,
  input  logic        p0_we,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [1:0]  p1_size,
  input  logic        p1_we,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        inwin_q, inwin_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        p0_ack_q, p0_ack_d;
  logic        p1_ack_q, p1_ack_d;
  logic        p0_err_q, p0_err_d;
  logic        p1_err_q, p1_err_d;

  logic        grant_port;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [1:0]  own_size;
  logic        own_we;
  logic [31:0] resp_data;

  // The memory-side fields always follow the current owner.
  always_comb begin
    own_addr  = owner_q ? p1_addr  : p0_addr;
    own_wdata = owner_q ? p1_wdata : p0_wdata;
    own_size  = owner_q ? p1_size  : p0_size;
    own_we    = owner_q ? p1_we    : p0_we;
  end

  assign mem_addr  = own_addr;
  assign mem_wdata = own_wdata;
  assign mem_size  = own_size;
  // The strobes are active only in ACCESS and only inside the window.
  // The reset term stops an aborted access from committing a write at that edge.
  assign mem_re    = (state_q == ACCESS) & ~own_we & inwin_q;
  assign mem_we    = (state_q == ACCESS) & own_we & inwin_q & ~reset;

  assign resp_data = (own_we | ~inwin_q) ? 32'h0 : mem_rdata;

  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

  // Next-state logic: grant in IDLE, capture the response in ACCESS, retire in RESP.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    inwin_d      = inwin_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_err_d     = 1'b0;
    p1_err_d     = 1'b0;
    grant_port   = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          // When both ports request, the port that was not served last wins.
          grant_port = (p0_req && p1_req) ? ~last_owner_q : p1_req;
          owner_d    = grant_port;
          inwin_d    = ((grant_port ? p1_addr[31:16] : p0_addr[31:16]) == MEM_ADDR);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (owner_q) begin
          p1_rdata_d = resp_data;
          p1_ack_d   = 1'b1;
          p1_err_d   = ~inwin_q;
        end else begin
          p0_rdata_d = resp_data;
          p0_ack_d   = 1'b1;
          p0_err_d   = ~inwin_q;
        end
        last_owner_d = owner_q;
        state_d      = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset takes priority over every transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= RR_INIT;
      inwin_q      <= 1'b0;
      p0_rdata_q   <= 32'h0;
      p1_rdata_q   <= 32'h0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      inwin_q      <= inwin_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_err_q     <= p0_err_d;
      p1_err_q     <= p1_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. It includes a byte-lane data memory model
// with a combinational read and a write on the clock edge.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        p0_req, p1_req;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [1:0]  p0_size, p1_size;
  logic        p0_we, p1_we;
  logic        p0_ack, p1_ack, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_we, mem_re;

  int checks;
  int failures;
  logic [31:0] hold0, hold1;

  logic [31:0] mem [0:255];

  mem_arbiter #(.MEM_ADDR(16'h1000), .RR_INIT(1'b1)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_size(p0_size), .p0_we(p0_we),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_size(p1_size), .p1_we(p1_we),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: byte writes use wdata[7:0] in lane addr[1:0], halfword writes use
  // wdata[15:0] in half addr[1], and the unaligned code writes nothing.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clock) begin
    if (mem_we) begin
      case (mem_size)
        2'd0: mem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        2'd1: mem[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        2'd3: mem[mem_addr[9:2]] <= mem_wdata;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        we;
    logic        exp_mem_we;
    logic        exp_mem_re;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    hold0 = 32'h0;
    hold1 = 32'h0;
  endtask

  // Runs one complete transaction: grant edge, ACCESS, RESP, and a return to IDLE.
  task automatic do_txn(input vec_t v);
    if (v.port) begin
      p1_addr = v.addr; p1_wdata = v.wdata; p1_size = v.size; p1_we = v.we; p1_req = 1'b1;
    end else begin
      p0_addr = v.addr; p0_wdata = v.wdata; p0_size = v.size; p0_we = v.we; p0_req = 1'b1;
    end
    tick();
    chk("access_mem_we", {31'h0, mem_we}, {31'h0, v.exp_mem_we});
    chk("access_mem_re", {31'h0, mem_re}, {31'h0, v.exp_mem_re});
    chk("access_mem_addr", mem_addr, v.addr);
    chk("access_mem_size", {30'h0, mem_size}, {30'h0, v.size});
    if (v.we) chk("access_mem_wdata", mem_wdata, v.wdata);
    chk("access_no_ack", {31'h0, p0_ack | p1_ack}, 32'h0);
    tick();
    if (v.port) begin
      chk("resp_ack", {31'h0, p1_ack}, 32'h1);
      chk("resp_err", {31'h0, p1_err}, {31'h0, v.exp_err});
      chk("resp_rdata", p1_rdata, v.exp_rdata);
      chk("other_ack", {31'h0, p0_ack}, 32'h0);
      chk("other_rdata_hold", p0_rdata, hold0);
      hold1 = v.exp_rdata;
    end else begin
      chk("resp_ack", {31'h0, p0_ack}, 32'h1);
      chk("resp_err", {31'h0, p0_err}, {31'h0, v.exp_err});
      chk("resp_rdata", p0_rdata, v.exp_rdata);
      chk("other_ack", {31'h0, p1_ack}, 32'h0);
      chk("other_rdata_hold", p1_rdata, hold1);
      hold0 = v.exp_rdata;
    end
    chk("resp_mem_we_idle", {31'h0, mem_we | mem_re}, 32'h0);
    $display("txn port=%0d addr=%h we=%0d size=%0d err=%0d rdata=%h",
             v.port, v.addr, v.we, v.size, v.port ? p1_err : p0_err, v.port ? p1_rdata : p0_rdata);
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    chk("idle_ack_clear", {31'h0, p0_ack | p1_ack}, 32'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    p0_addr = 32'h0; p0_wdata = 32'h0; p0_size = 2'd0; p0_we = 1'b0;
    p1_addr = 32'h0; p1_wdata = 32'h0; p1_size = 2'd0; p1_we = 1'b0;

    //            port  addr          wdata         sz    we    mwe   mre   err   rdata
    vecs[0]  = '{1'b0, 32'h10000010, 32'hDEADBEEF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10000010, 32'h0,        2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h20000000, 32'h12345678, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h10000020, 32'h11223344, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h10000021, 32'h000000AB, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h10000020, 32'h0,        2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1122AB44};
    vecs[6]  = '{1'b1, 32'h10000032, 32'h0000BEEF, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h10000030, 32'h0,        2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'hBEEF0000};
    vecs[8]  = '{1'b1, 32'h10000040, 32'h00000055, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h10000040, 32'h0,        2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h30001000, 32'h0,        2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};

    // Reset state
    do_reset();
    chk("reset_p0_ack", {31'h0, p0_ack}, 32'h0);
    chk("reset_p1_ack", {31'h0, p1_ack}, 32'h0);
    chk("reset_errs", {31'h0, p0_err | p1_err}, 32'h0);
    chk("reset_p0_rdata", p0_rdata, 32'h0);
    chk("reset_p1_rdata", p1_rdata, 32'h0);
    chk("reset_strobes", {31'h0, mem_we | mem_re}, 32'h0);

    // Table of single transactions
    for (int i = 0; i < 11; i++) do_txn(vecs[i]);

    // Both ports request continuously from reset: grants 0,1,0,1
    do_reset();
    p0_addr = 32'h10000010; p0_we = 1'b0; p0_size = 2'd3;
    p1_addr = 32'h10000030; p1_we = 1'b0; p1_size = 2'd3;
    p0_req = 1'b1;
    p1_req = 1'b1;
    begin
      int acks;
      acks = 0;
      for (int c = 1; c <= 12; c++) begin
        tick();
        chk("rr_p0_ack", {31'h0, p0_ack}, {31'h0, (c == 2 || c == 8)});
        chk("rr_p1_ack", {31'h0, p1_ack}, {31'h0, (c == 5 || c == 11)});
        if (p0_ack) chk("rr_p0_rdata", p0_rdata, 32'hDEADBEEF);
        if (p1_ack) chk("rr_p1_rdata", p1_rdata, 32'hBEEF0000);
        acks += int'(p0_ack) + int'(p1_ack);
      end
      chk("rr_ack_total", acks, 32'd4);
      $display("txn round_robin acks=%0d", acks);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();
    tick();

    // Lone requester p1 issues three reads back to back
    p1_addr = 32'h10000030; p1_we = 1'b0; p1_size = 2'd3;
    p1_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("lone_p1_ack", {31'h0, p1_ack}, {31'h0, (c == 2 || c == 5 || c == 8)});
      chk("lone_p0_ack", {31'h0, p0_ack}, 32'h0);
    end
    $display("txn lone_p1 three reads rdata=%h", p1_rdata);
    p1_req = 1'b0;
    tick();
    tick();
    tick();

    // Reset during the ACCESS cycle of a write aborts it
    p0_addr = 32'h10000010; p0_wdata = 32'hCAFEF00D; p0_size = 2'd3; p0_we = 1'b1;
    p0_req = 1'b1;
    tick();
    chk("abort_access_we", {31'h0, mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_we_masked", {31'h0, mem_we}, 32'h0);
    tick();
    reset = 1'b0;
    p0_req = 1'b0;
    hold0 = 32'h0;
    hold1 = 32'h0;
    chk("abort_no_ack", {31'h0, p0_ack}, 32'h0);
    tick();
    chk("abort_no_ack_later", {31'h0, p0_ack}, 32'h0);
    $display("txn aborted write by reset");
    do_txn(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
